comparator_pipe: RTL and testbench

Parametrised, multi-cycle magnitude comparator: compares two WIDTH-bit operands SLICE bits per cycle, most-significant slice first, and stops at the first slice that differs. It supports an unsigned or two's-complement mode, selected per transaction. Operands enter through a valid/ready handshake. The result is a registered one-hot Y2/Y1/Y0 triple with a one-cycle out_valid strobe. It replaces single-cycle 4-bit comparators wherever wide operands would break timing.

---
 rtl/comparator_pipe.sv | 142 ++++++++++++++
 tb/tb_comparator_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/comparator_pipe.sv
// comparator_pipe: multi-cycle magnitude comparator that walks the operands
// SLICE bits per cycle from the most-significant end, stopping at the first
// slice that differs. Supports unsigned and two's-complement compares.
// WIDTH must be a non-zero multiple of SLICE.
module comparator_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   output logic             Y2,
   output logic             Y1,
   output logic             Y0,
   output logic             busy
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned IDW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDW-1:0] TOP_IDX = IDW'(NSLICE - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, w_a_nxt;
   logic [WIDTH-1:0] r_b, w_b_nxt;
   logic             r_signed, w_signed_nxt;
   logic [IDW-1:0]   r_idx, w_idx_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic             r_y2, w_y2_nxt;
   logic             r_y1, w_y1_nxt;
   logic             r_y0, w_y0_nxt;

   logic [SLICE-1:0] w_a_slice [NSLICE];
   logic [SLICE-1:0] w_b_slice [NSLICE];
   logic [SLICE-1:0] w_sa, w_sb;
   logic             w_flip;
   logic             w_accept;

   // Split latched operands into slices so the active one can be muxed by index
   for (genvar g = 0; g < NSLICE; g++) begin : g_slice
      assign w_a_slice[g] = r_a[g*SLICE +: SLICE];
      assign w_b_slice[g] = r_b[g*SLICE +: SLICE];
   end

   assign w_flip   = r_signed && (r_idx == TOP_IDX);
   assign w_accept = in_valid && (r_state == ST_IDLE);

   // Select current slice pair; sign-flip the top slice so an unsigned compare
   // orders two's-complement values correctly
   always_comb begin
      w_sa = w_a_slice[r_idx];
      w_sb = w_b_slice[r_idx];
      w_sa[SLICE-1] = w_sa[SLICE-1] ^ w_flip;
      w_sb[SLICE-1] = w_sb[SLICE-1] ^ w_flip;
   end

   // Next-state logic: accept in IDLE, walk slices in RUN, stop on first difference
   always_comb begin
      w_state_nxt     = r_state;
      w_a_nxt         = r_a;
      w_b_nxt         = r_b;
      w_signed_nxt    = r_signed;
      w_idx_nxt       = r_idx;
      w_out_valid_nxt = 1'b0;
      w_y2_nxt        = r_y2;
      w_y1_nxt        = r_y1;
      w_y0_nxt        = r_y0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_a_nxt      = A;
               w_b_nxt      = B;
               w_signed_nxt = signed_mode;
               w_idx_nxt    = TOP_IDX;
               w_state_nxt  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_sa != w_sb) begin
               w_y2_nxt        = (w_sa > w_sb);
               w_y1_nxt        = 1'b0;
               w_y0_nxt        = (w_sa < w_sb);
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = ST_IDLE;
            end else if (r_idx == '0) begin
               w_y2_nxt        = 1'b0;
               w_y1_nxt        = 1'b1;
               w_y0_nxt        = 1'b0;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = ST_IDLE;
            end else begin
               w_idx_nxt = r_idx - 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and result registers; async reset aborts any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_signed    <= 1'b0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_y2        <= 1'b0;
         r_y1        <= 1'b0;
         r_y0        <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_signed    <= w_signed_nxt;
         r_idx       <= w_idx_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_y2        <= w_y2_nxt;
         r_y1        <= w_y1_nxt;
         r_y0        <= w_y0_nxt;
      end
   end

   // Output drive
   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      busy      = (r_state != ST_IDLE);
      out_valid = r_out_valid;
      Y2        = r_y2;
      Y1        = r_y1;
      Y0        = r_y0;
   end

endmodule

// File: tb/tb_comparator_pipe.sv
// Scoreboard bench for comparator_pipe (WIDTH=16, SLICE=4).
module tb_comparator_pipe;

   localparam int W  = 16;
   localparam int S  = 4;
   localparam int NS = W / S;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         signed_mode = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         out_valid;
   logic         y2, y1, y0;
   logic         busy;

   typedef struct {
      logic [2:0] res;
      int         edge_n;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   comparator_pipe #(.WIDTH(W), .SLICE(S)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .signed_mode(signed_mode),
      .A          (a_in),
      .B          (b_in),
      .out_valid  (out_valid),
      .Y2         (y2),
      .Y1         (y1),
      .Y0         (y0),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Rising-edge counter; edge numbering for latency checks
   always @(posedge clk) cyc++;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: result from native compare, latency from slice-by-slice scan
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  input int acc_edge);
      exp_t        e;
      logic [W-1:0] fa, fb;
      int          eq;
      fa = a;
      fb = b;
      if (s) begin
         fa[W-1] = ~fa[W-1];
         fb[W-1] = ~fb[W-1];
      end
      eq = 0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (fa[i*S +: S] == fb[i*S +: S]) eq++;
         else break;
      end
      if (s) e.res = {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
      else   e.res = {a > b, a == b, a < b};
      e.edge_n = acc_edge + ((eq >= NS) ? NS : eq + 1);
      return e;
   endfunction

   // Monitor: compare every out_valid against the scoreboard head
   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) begin
            check_value("spurious_out_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_value("result", {29'd0, y2, y1, y0}, {29'd0, e.res});
            check_value("latency_edge", cyc, e.edge_n);
         end
      end
   end

   // Present one transaction; waits (bounded) for in_ready, accepts on next edge
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit expect_result, input bit hold_valid);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check_value("in_ready_timeout", 32'd0, 32'd1);
      in_valid    = 1'b1;
      a_in        = a;
      b_in        = b;
      signed_mode = s;
      if (expect_result) sb.push_back(model(a, b, s, cyc + 1));
      @(posedge clk);
      #1;
      if (!hold_valid) in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check_value("drain_timeout", sb.size(), 32'd0);
   endtask

   initial begin
      // Reset state, during and after reset
      repeat (2) @(negedge clk);
      check_value("reset_hold_outs", {26'd0, in_ready, busy, out_valid, y2, y1, y0}, 32'b100000);
      rst_n = 1'b1;
      @(negedge clk);
      check_value("reset_rel_outs", {26'd0, in_ready, busy, out_valid, y2, y1, y0}, 32'b100000);

      // Equality: full NSLICE latency
      send(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);
      drain();

      // Sign mode early exit
      send(16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      drain();
      send(16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      drain();

      // Mid-slice decision; traffic while busy is ignored
      send(16'h12E0, 16'h12F0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      a_in     = 16'hFFFF;
      check_value("busy_in_ready", {31'd0, in_ready}, 32'd0);
      check_value("busy_flag", {31'd0, busy}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      drain();

      // Back-to-back with in_valid held high
      send(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1);
      send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      drain();

      // Reset mid-operation: no result, outputs back to reset values
      send(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_value("midrst_outs", {26'd0, in_ready, busy, out_valid, y2, y1, y0}, 32'b100000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check_value("post_rst_idle", {29'd0, in_ready, busy, out_valid}, 32'b100);
      end

      // Random mixed traffic, including near-equal operands
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = (i % 3 == 0) ? (ra ^ W'(1 << $urandom_range(0, W - 1))) : W'($urandom);
         if (i % 5 == 0) rb = ra;
         send(ra, rb, 1'(i % 2), 1'b1, 1'(i % 4 == 1));
      end
      in_valid = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      check_value("scoreboard_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
